// File: rtl/key_debounce_if.sv
// Pushbutton bundle: raw active-low pins toward the debouncer, clean
// active-high levels and one-cycle press/release pulses back to the consumer.
interface key_debounce_if #(
  parameter int N_KEYS = 4
) ();
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output key,
    input  key_state,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key,
    output key_state,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser, counter debounce FSM and press/release pulse generator.
// Optional auto-repeat of key_press while held is enabled by defining KEY_REPEAT_EN.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic          clk,
  input  logic          reset,
  key_debounce_if.slave kb
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
`else
  // Repeat parameters stay in the interface so both builds share one instantiation.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
  end
`endif

  logic [N_KEYS-1:0] state_vec;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] rel_vec;

  assign kb.key_state   = state_vec;
  assign kb.key_press   = press_vec;
  assign kb.key_release = rel_vec;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   rep_fire;

    // Only the last synchroniser stage is ever looked at; s is 1 when pressed.
    assign s = ~sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (s) begin
            state_d = ST_PRESS_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_PEND: begin
          if (!s) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d = ST_REL_PEND;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          if (s) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

`ifdef KEY_REPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;

    // Counts cycles spent stably in PRESSED; first pulse after the long
    // delay, then the counter restarts and fires every period.
    always_comb begin
      rep_d       = '0;
      rep_first_d = 1'b0;
      rep_fire    = 1'b0;
      if (state_q == ST_PRESSED && s) begin
        rep_d       = rep_q + RW'(1);
        rep_first_d = rep_first_q;
        if (!rep_first_q && int'(rep_d) == REPEAT_DELAY) begin
          rep_fire    = 1'b1;
          rep_first_d = 1'b1;
          rep_d       = '0;
        end else if (rep_first_q && int'(rep_d) == REPEAT_PERIOD) begin
          rep_fire = 1'b1;
          rep_d    = '0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rep_q       <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_q       <= rep_d;
        rep_first_q <= rep_first_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q  <= '1;
        state_q <= ST_RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], kb.key[g]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d | rep_fire;
        rel_q   <= rel_d;
      end
    end

    assign state_vec[g] = lvl_q;
    assign press_vec[g] = press_q;
    assign rel_vec[g]   = rel_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model checked every cycle,
// directed scenarios with literal timing expectations, then random bouncing keys.
module tb_key_debounce;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int SY  = 2;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk;
  logic reset;

  key_debounce_if #(.N_KEYS(N)) kb ();

  key_debounce #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SY),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kb(kb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for DB consecutive samples; repeats fire at held = RD, RD+RP, ...
  logic [N-1:0] hist [SY];
  int           run  [N];
  int           held [N];
  logic [N-1:0] m_lvl, m_press, m_rel;
  bit           mvalid = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < SY; i++) hist[i] = '1;
        for (int k = 0; k < N; k++) begin run[k] = 0; held[k] = 0; end
        m_lvl = '0; m_press = '0; m_rel = '0;
        mvalid = 1;
      end else if (mvalid) begin
        for (int k = 0; k < N; k++) begin
          logic sk;
          bit   stable_on;
          sk = ~hist[SY-1][k];
          stable_on = (m_lvl[k] == 1'b1) && (run[k] == 0);
          m_press[k] = 1'b0;
          m_rel[k]   = 1'b0;
          if (sk != m_lvl[k]) run[k]++;
          else run[k] = 0;
          if (run[k] == DB) begin
            m_lvl[k] = sk;
            if (sk) m_press[k] = 1'b1;
            else    m_rel[k]   = 1'b1;
            run[k] = 0;
          end
`ifdef KEY_REPEAT_EN
          if (stable_on && sk) begin
            held[k]++;
            if (held[k] >= RD && ((held[k] - RD) % RP) == 0) m_press[k] = 1'b1;
          end else begin
            held[k] = 0;
          end
`else
          if (stable_on) held[k] = 0;
`endif
        end
        for (int i = SY - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = kb.key;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid)
        chk("outputs_vs_model", {20'd0, kb.key_state, kb.key_press, kb.key_release},
            {20'd0, m_lvl, m_press, m_rel});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first_rep, rep_cnt, exp_cnt, exp_first;
    bit saw;
    logic [N-1:0] hold_lvl;
    int           hold_t [N];

    reset  = 1'b1;
    kb.key = '1;
    step(2);
    chk("reset_state",   {28'd0, kb.key_state},   32'd0);
    chk("reset_press",   {28'd0, kb.key_press},   32'd0);
    chk("reset_release", {28'd0, kb.key_release}, 32'd0);
    reset = 1'b0;
    step(20);
    chk("idle_outputs", {20'd0, kb.key_state, kb.key_press, kb.key_release}, 32'd0);

    // Clean press and release on key 0.
    kb.key[0] = 1'b0;
    step(5);
    chk("press0_early", {31'd0, kb.key_press[0]}, 32'd0);
    step(1);
    chk("press0_pulse", {30'd0, kb.key_state[0], kb.key_press[0]}, 32'd3);
    step(1);
    chk("press0_once",  {30'd0, kb.key_state[0], kb.key_press[0]}, 32'd2);
    kb.key[0] = 1'b1;
    step(5);
    chk("rel0_early", {31'd0, kb.key_release[0]}, 32'd0);
    step(1);
    chk("rel0_pulse", {30'd0, kb.key_state[0], kb.key_release[0]}, 32'd1);
    step(4);

    // Bouncing key 1 never settles long enough.
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      kb.key[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      if (kb.key_state[1] || kb.key_press[1] || kb.key_release[1]) saw = 1;
    end
    kb.key[1] = 1'b1;
    step(8);
    kb.key[1] = 1'b0;
    step(3);
    kb.key[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (kb.key_state[1] || kb.key_press[1] || kb.key_release[1]) saw = 1;
    end
    chk("bounce_no_event", {31'd0, saw}, 32'd0);

    // Two keys pressed together.
    kb.key = 4'b0101;
    step(5);
    chk("parallel_early", {28'd0, kb.key_press}, 32'd0);
    step(1);
    chk("parallel_press", {28'd0, kb.key_press}, 32'hA);
    chk("parallel_state", {28'd0, kb.key_state}, 32'hA);
    kb.key = 4'b1111;
    step(12);

    // Reset while key 2 is mid-debounce; the held key re-presses afterwards.
    kb.key[2] = 1'b0;
    step(4);
    chk("midrst_no_pulse", {28'd0, kb.key_press}, 32'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    chk("midrst_early", {31'd0, kb.key_press[2]}, 32'd0);
    step(1);
    chk("midrst_press", {30'd0, kb.key_state[2], kb.key_press[2]}, 32'd3);
    kb.key[2] = 1'b1;
    step(12);

    // Long hold on key 3.
    kb.key[3] = 1'b0;
    step(6);
    chk("hold3_accept", {31'd0, kb.key_press[3]}, 32'd1);
    first_rep = -1;
    rep_cnt   = 0;
    for (int j = 1; j <= 30; j++) begin
      step(1);
      if (kb.key_press[3]) begin
        rep_cnt++;
        if (first_rep < 0) first_rep = j;
      end
    end
`ifdef KEY_REPEAT_EN
    exp_cnt = 7;  exp_first = 10;
`else
    exp_cnt = 0;  exp_first = -1;
`endif
    chk("repeat_count", rep_cnt, exp_cnt);
    chk("repeat_first", first_rep, exp_first);
    chk("hold3_state",  {31'd0, kb.key_state[3]}, 32'd1);
    kb.key[3] = 1'b1;
    step(12);

    // Random bouncing and holding on all keys, with rare resets.
    hold_lvl = '1;
    for (int k = 0; k < N; k++) hold_t[k] = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        hold_t[k]--;
        if (hold_t[k] <= 0) begin
          hold_lvl[k] = ~hold_lvl[k];
          hold_t[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 30));
        end
      end
      kb.key = hold_lvl;
      reset  = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset  = 1'b0;
    kb.key = '1;
    step(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
